palindrome_seq_ctrl: RTL and testbench



---
 rtl/palindrome_seq_ctrl_pkg.sv | 22 ++
 rtl/palindrome_seq_ctrl_if.sv | 42 ++++
 rtl/palindrome_seq_ctrl_bin2bcd_seq.sv | 70 +++++++
 rtl/palindrome_seq_ctrl.sv | 151 +++++++++++++++
 tb/tb_palindrome_seq_ctrl.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/palindrome_seq_ctrl_pkg.sv
// Shared types and helpers for the decimal-palindrome controller.
// Optional feature macro: PAL_BCD_OUT_EN (adds the bcd_digits result port).
package pal_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    CONVERT,
    LEN,
    COMPARE,
    DONE
  } state_e;

  // Decimal digits needed for 2^w-1; 2^w is never a power of ten, so
  // floor(w*log10(2))+1 is exact for any positive w.
  function automatic int digits_for_width(input int w);
    if (w <= 0) return 1;
    return (w * 30103) / 100000 + 1;
  endfunction

endpackage

// File: rtl/palindrome_seq_ctrl_if.sv
// Number-in / verdict-out bundle for palindrome_seq_ctrl.
// Optional feature macro: PAL_BCD_OUT_EN (adds bcd_digits).
// Handshake: a transfer happens on a rising clk edge where valid && ready;
// a source holds its payload stable while valid is high and unaccepted.
interface palindrome_seq_ctrl_if #(
  parameter int WIDTH      = 10,
  parameter int MAX_DIGITS = 4
);
  import pal_pkg::*;

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] number;
  logic             out_valid;
  logic             out_ready;
  logic             is_palindrome;
  logic [CNT_W-1:0] num_digits;
  logic             busy;
  state_e           dbg_state;
`ifdef PAL_BCD_OUT_EN
  logic [BCD_W*MAX_DIGITS-1:0] bcd_digits;
`endif

  modport master (
    output in_valid, number, out_ready,
    input  in_ready, out_valid, is_palindrome, num_digits, busy, dbg_state
`ifdef PAL_BCD_OUT_EN
    , input bcd_digits
`endif
  );

  modport slave (
    input  in_valid, number, out_ready,
    output in_ready, out_valid, is_palindrome, num_digits, busy, dbg_state
`ifdef PAL_BCD_OUT_EN
    , output bcd_digits
`endif
  );

endinterface

// File: rtl/palindrome_seq_ctrl_bin2bcd_seq.sv
// Iterative double-dabble converter: one input bit per cycle, fixed WIDTH-cycle run.
// done_o pulses for one cycle after the last shift; bcd_o then holds until the next start.
module bin2bcd_seq
  import pal_pkg::*;
#(
  parameter int WIDTH      = 10,
  parameter int MAX_DIGITS = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_i,
  input  logic [WIDTH-1:0]            bin_i,
  output logic [BCD_W*MAX_DIGITS-1:0] bcd_o,
  output logic                        done_o
);

  localparam int BW = BCD_W * MAX_DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] bin_q;
  logic [BW-1:0]    bcd_q;
  logic [BW-1:0]    adj;
  logic [BW-1:0]    bcd_d;
  logic [CW-1:0]    cnt_q;
  logic             run_q;
  logic             done_q;

  // Correct every digit that would overflow past 9 once doubled.
  always_comb begin
    adj = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (bcd_q[i*BCD_W +: BCD_W] >= 4'd5) begin
        adj[i*BCD_W +: BCD_W] = bcd_q[i*BCD_W +: BCD_W] + 4'd3;
      end else begin
        adj[i*BCD_W +: BCD_W] = bcd_q[i*BCD_W +: BCD_W];
      end
    end
    bcd_d = {adj[BW-2:0], bin_q[WIDTH-1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        bin_q <= bin_i;
        bcd_q <= '0;
        cnt_q <= '0;
        run_q <= 1'b1;
      end else if (run_q) begin
        bcd_q <= bcd_d;
        bin_q <= bin_q << 1;
        cnt_q <= cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign bcd_o  = bcd_q;
  assign done_o = done_q;

endmodule

// File: rtl/palindrome_seq_ctrl.sv
// Decimal-palindrome controller: convert to BCD, measure length, compare outer digit pairs.
// Optional feature macro: PAL_BCD_OUT_EN (exposes the converted BCD value with the result).
module palindrome_seq_ctrl
  import pal_pkg::*;
#(
  parameter int WIDTH      = 10,
  parameter int MAX_DIGITS = 4
) (
  input logic                 clk,
  input logic                 rst,
  palindrome_seq_ctrl_if.slave io
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);
  localparam int IDX_W = (MAX_DIGITS > 1) ? $clog2(MAX_DIGITS) : 1;
  localparam int BW    = BCD_W * MAX_DIGITS;

  generate
    if (MAX_DIGITS < digits_for_width(WIDTH)) begin : g_bad_cfg
      $error("palindrome_seq_ctrl: MAX_DIGITS too small for 2^WIDTH-1");
    end
  endgenerate

  state_e           state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;
  logic             is_pal_q;
  logic [CNT_W-1:0] num_digits_q;
  logic [CNT_W-1:0] n_q;
  logic [IDX_W-1:0] lo_q;
  logic [IDX_W-1:0] hi_q;
`ifdef PAL_BCD_OUT_EN
  logic [BW-1:0]    bcd_out_q;
`endif

  logic             start;
  logic             conv_done;
  logic [BW-1:0]    bcd_w;
  logic [3:0]       dig [MAX_DIGITS];
  logic [CNT_W-1:0] n_calc;
  logic             pair_last;

  assign start = (state_q == IDLE) && io.in_valid && in_ready_q;

  bin2bcd_seq #(
    .WIDTH      (WIDTH),
    .MAX_DIGITS (MAX_DIGITS)
  ) u_conv (
    .clk     (clk),
    .rst     (rst),
    .start_i (start),
    .bin_i   (io.number),
    .bcd_o   (bcd_w),
    .done_o  (conv_done)
  );

  // Significant length: leading zero digits never count, and zero itself is one digit.
  always_comb begin
    n_calc = CNT_W'(1);
    for (int i = 0; i < MAX_DIGITS; i++) begin
      dig[i] = bcd_w[i*BCD_W +: BCD_W];
      if (bcd_w[i*BCD_W +: BCD_W] != 4'd0) n_calc = CNT_W'(i + 1);
    end
  end

  // After this pair the indices would meet or cross, so nothing is left to compare.
  assign pair_last = (int'(lo_q) + 2) >= int'(hi_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      is_pal_q     <= 1'b0;
      num_digits_q <= '0;
      n_q          <= '0;
      lo_q         <= '0;
      hi_q         <= '0;
`ifdef PAL_BCD_OUT_EN
      bcd_out_q    <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= CONVERT;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        CONVERT: begin
          if (conv_done) state_q <= LEN;
        end
        LEN: begin
          lo_q <= '0;
          hi_q <= IDX_W'(n_calc - CNT_W'(1));
          n_q  <= n_calc;
`ifdef PAL_BCD_OUT_EN
          bcd_out_q <= bcd_w;
`endif
          if (n_calc == CNT_W'(1)) begin
            is_pal_q     <= 1'b1;
            num_digits_q <= n_calc;
            out_valid_q  <= 1'b1;
            state_q      <= DONE;
          end else begin
            state_q <= COMPARE;
          end
        end
        COMPARE: begin
          if (dig[lo_q] != dig[hi_q]) begin
            is_pal_q     <= 1'b0;
            num_digits_q <= n_q;
            out_valid_q  <= 1'b1;
            state_q      <= DONE;
          end else if (pair_last) begin
            is_pal_q     <= 1'b1;
            num_digits_q <= n_q;
            out_valid_q  <= 1'b1;
            state_q      <= DONE;
          end else begin
            lo_q <= lo_q + IDX_W'(1);
            hi_q <= hi_q - IDX_W'(1);
          end
        end
        DONE: begin
          if (io.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign io.in_ready      = in_ready_q;
  assign io.out_valid     = out_valid_q;
  assign io.busy          = busy_q;
  assign io.is_palindrome = is_pal_q;
  assign io.num_digits    = num_digits_q;
  assign io.dbg_state     = state_q;
`ifdef PAL_BCD_OUT_EN
  assign io.bcd_digits    = bcd_out_q;
`endif

endmodule

// File: tb/tb_palindrome_seq_ctrl.sv
// Bench for palindrome_seq_ctrl: decimal-digit reference model, per-cycle compare, result scoreboard.
// Build with PAL_BCD_OUT_EN defined to also check bcd_digits.
module tb_palindrome_seq_ctrl;
  import pal_pkg::*;

  localparam int WIDTH = 10;
  localparam int MAXD  = 4;
  localparam int CNT_W = 3;
  localparam int BW    = 16;
  localparam int EXP_W = 8 + BW + 1 + CNT_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  palindrome_seq_ctrl_if #(.WIDTH(WIDTH), .MAX_DIGITS(MAXD)) pif ();

  palindrome_seq_ctrl #(.WIDTH(WIDTH), .MAX_DIGITS(MAXD)) dut (
    .clk (clk),
    .rst (rst),
    .io  (pif)
  );

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  logic [EXP_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    fails++;
    $display("FAIL %s: actual=timeout required=event at %0t", name, $time);
  endtask

  // ---------------- reference model ----------------
  // Decimal digits via %10, pair comparisons counted from the outside in.
  function automatic void model_num(input int unsigned v, output bit pal, output int nd,
                                    output int p, output int bcd);
    int d[$];
    int unsigned x = v;
    do begin
      d.push_back(int'(x % 10));
      x = x / 10;
    end while (x > 0);
    nd  = d.size();
    pal = 1'b1;
    p   = 0;
    for (int i = 0; i < nd / 2; i++) begin
      p++;
      if (d[i] != d[nd-1-i]) begin
        pal = 1'b0;
        break;
      end
    end
    bcd = 0;
    for (int i = 0; i < nd; i++) bcd += d[i] << (4 * i);
  endfunction

  function automatic logic [EXP_W-1:0] pack(input bit pal, input int nd, input int lat, input int bcd);
    return {8'(lat), 16'(bcd), pal, 3'(nd)};
  endfunction

  bit m_ready = 1'b1, m_outv = 1'b0, m_pal = 1'b0;
  int m_nd = 0, m_bcd = 0, m_cnt = 0, m_lat = 0;
  bit e_pal;
  int e_nd, e_bcd, e_p;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ready = 1'b1; m_outv = 1'b0; m_pal = 1'b0; m_nd = 0; m_bcd = 0; m_cnt = 0;
    end else begin
      cyc++;
      if (m_ready) begin
        if (pif.in_valid) begin
          model_num(pif.number, e_pal, e_nd, e_p, e_bcd);
          m_lat   = WIDTH + 2 + e_p;
          m_cnt   = 0;
          m_ready = 1'b0;
        end
      end else if (!m_outv) begin
        m_cnt++;
        if (m_cnt == m_lat) begin
          m_outv = 1'b1; m_pal = e_pal; m_nd = e_nd; m_bcd = e_bcd;
        end
      end else if (pif.out_ready) begin
        m_outv  = 1'b0;
        m_ready = 1'b1;
      end
    end
  end

  // ---------------- per-cycle compare + scoreboard ----------------
  int acc_cyc = 0, lat_meas = 0;
  bit prev_ov = 1'b0;
  logic [EXP_W-1:0] e;

  always @(negedge clk) begin
    check("in_ready", pif.in_ready, m_ready);
    check("busy", pif.busy, !m_ready);
    check("out_valid", pif.out_valid, m_outv);
    check("is_palindrome", pif.is_palindrome, m_pal);
    check("num_digits", pif.num_digits, m_nd);
`ifdef PAL_BCD_OUT_EN
    if (m_outv) check("bcd_digits", pif.bcd_digits, m_bcd);
`endif
    if (pif.in_valid && pif.in_ready) acc_cyc = cyc + 1;
    if (pif.out_valid && !prev_ov) lat_meas = cyc - acc_cyc;
    prev_ov = pif.out_valid;
    if (pif.out_valid && pif.out_ready) begin
      if (exp_q.size() == 0) begin
        fail_now("sb_unexpected_result");
      end else begin
        e = exp_q.pop_front();
        check("sb_is_palindrome", pif.is_palindrome, e[CNT_W]);
        check("sb_num_digits", pif.num_digits, e[CNT_W-1:0]);
        check("sb_latency", lat_meas, e[EXP_W-1 -: 8]);
`ifdef PAL_BCD_OUT_EN
        check("sb_bcd_digits", pif.bcd_digits, e[CNT_W+1 +: BW]);
`endif
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_accept(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pif.in_ready) begin ok = 1'b1; break; end
    end
  endtask

  task automatic do_txn(input int unsigned num, input logic [EXP_W-1:0] ex, input int hold);
    bit ok;
    exp_q.push_back(ex);
    @(posedge clk); #2;
    pif.in_valid  = 1'b1;
    pif.number    = WIDTH'(num);
    pif.out_ready = (hold == 0);
    wait_accept(ok);
    if (!ok) fail_now("accept_timeout");
    @(posedge clk); #2;
    pif.in_valid = 1'b0;
    pif.number   = WIDTH'($urandom);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (pif.out_valid) begin ok = 1'b1; break; end
    end
    if (!ok) fail_now("out_valid_timeout");
    if (hold > 0) begin
      repeat (hold) begin
        @(posedge clk); #2;
        pif.in_valid = 1'($urandom_range(0, 1));
        pif.number   = WIDTH'($urandom);
      end
      @(posedge clk); #2;
      pif.in_valid  = 1'b0;
      pif.out_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #2;
    pif.out_ready = 1'b0;
  endtask

  task automatic rand_txn();
    int unsigned v;
    bit pal;
    int nd, p, bcd;
    v = $urandom_range(0, (1 << WIDTH) - 1);
    model_num(v, pal, nd, p, bcd);
    do_txn(v, pack(pal, nd, WIDTH + 2 + p, bcd), $urandom_range(0, 3));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit ok;
    rst           = 1'b1;
    pif.in_valid  = 1'b0;
    pif.out_ready = 1'b0;
    pif.number    = '0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_in_ready", pif.in_ready, 1);
    check("rst_out_valid", pif.out_valid, 0);
    check("rst_busy", pif.busy, 0);
    check("rst_state", pif.dbg_state, IDLE);
    rst = 1'b0;

    do_txn(121,  pack(1, 3, 13, 'h0121), 0);
    do_txn(1001, pack(1, 4, 14, 'h1001), 0);
    do_txn(1023, pack(0, 4, 13, 'h1023), 0);
    do_txn(0,    pack(1, 1, 12, 'h0000), 0);
    do_txn(10,   pack(0, 2, 13, 'h0010), 0);
    do_txn(123,  pack(0, 3, 13, 'h0123), 5);
    do_txn(7,    pack(1, 1, 12, 'h0007), 0);

    // Reset in the middle of a conversion discards the number.
    @(posedge clk); #2;
    pif.in_valid = 1'b1;
    pif.number   = WIDTH'(999);
    wait_accept(ok);
    if (!ok) fail_now("accept_999_timeout");
    @(posedge clk); #2;
    pif.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_in_ready", pif.in_ready, 1);
    check("midrst_out_valid", pif.out_valid, 0);
    check("midrst_busy", pif.busy, 0);
    check("midrst_is_palindrome", pif.is_palindrome, 0);
    check("midrst_num_digits", pif.num_digits, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    exp_q.delete();

    do_txn(55, pack(1, 2, 13, 'h0055), 0);
    for (int i = 0; i < 30; i++) rand_txn();
    repeat (3) @(posedge clk);
    if (exp_q.size() != 0) fail_now("sb_results_missing");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
